romulus_round_sched: RTL and testbench



---
 rtl/romulus_round_sched_pkg.sv | 23 ++
 rtl/romulus_round_sched_rc_lfsr.sv | 30 +++
 rtl/romulus_round_sched.sv | 139 +++++++++++++
 tb/tb_romulus_round_sched.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/romulus_round_sched_pkg.sv
// Shared configuration for the Romulus round scheduler: default geometry,
// FSM state encodings and the round-constant LFSR update.
package romulus_round_sched_pkg;

  localparam int CONSTW_DEF       = 6;
  localparam int CLKS_PER_RND_DEF = 4;
  localparam int ROUNDS_DEF       = 40;
  localparam int MASKED_DEF       = 0;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic [5:0] RC_INIT = 6'h01;

  // SKINNY round-constant LFSR: shift left, feedback rc5 ^ rc4 ^ 1
  function automatic logic [5:0] rc_next(input logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/romulus_round_sched_rc_lfsr.sv
// 6-bit SKINNY round-constant LFSR with synchronous load and step; kept
// separate so a key-schedule tweak controller can reuse it.
module romulus_rc_lfsr
  import romulus_round_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [5:0] rc
);

  logic [5:0] rc_r;

  // Load takes priority over step; otherwise the constant holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rc_r <= 6'h00;
    end else if (load) begin
      rc_r <= RC_INIT;
    end else if (step) begin
      rc_r <= rc_next(rc_r);
    end else begin
      rc_r <= rc_r;
    end
  end

  assign rc = rc_r;

endmodule

// File: rtl/romulus_round_sched.sv
// Round scheduler for the SKINNY-128-384+ datapath: accepts one cipher call,
// walks ROUNDS x CLKS_PER_RND phases (optionally throttled by randomness) and
// reports completion with a held valid/ready handshake.
module romulus_round_sched
  import romulus_round_sched_pkg::*;
#(
  parameter int CONSTW       = CONSTW_DEF,
  parameter int CLKS_PER_RND = CLKS_PER_RND_DEF,
  parameter int ROUNDS       = ROUNDS_DEF,
  parameter int MASKED       = MASKED_DEF,
  parameter int RCW          = $clog2(ROUNDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic                    abort,
  input  logic                    rdi_valid,
  output logic                    rdi_ready,
  output logic [CONSTW-1:0]       constant,
  output logic [CLKS_PER_RND-1:0] enrnd,
  output logic                    sen,
  output logic [RCW-1:0]          round,
  output logic                    last_round,
  output logic                    done_valid,
  input  logic                    done_ready
);

  localparam int PHW = (CLKS_PER_RND > 1) ? $clog2(CLKS_PER_RND) : 1;
  localparam logic [PHW-1:0] PH_LAST  = PHW'(CLKS_PER_RND - 1);
  localparam logic [RCW-1:0] RND_LAST = RCW'(ROUNDS - 1);

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [PHW-1:0]          phase_r;
  logic [RCW-1:0]          round_r;
  logic [5:0]              rc_s;
  logic [CLKS_PER_RND-1:0] enrnd_s;
  logic                    run_s;
  logic                    done_st_s;
  logic                    adv_s;
  logic                    step_s;
  logic                    move_s;
  logic                    wrap_s;
  logic                    finish_s;
  logic                    accept_s;

  assign run_s     = (state_r == ST_RUN);
  assign done_st_s = (state_r == ST_DONE);
  assign adv_s     = (MASKED == 0) || rdi_valid;
  // step_s drives enrnd and must not see abort; move_s gates the state update
  assign step_s    = run_s && adv_s;
  assign move_s    = step_s && !abort;
  assign wrap_s    = move_s && (phase_r == PH_LAST);
  assign finish_s  = wrap_s && (round_r == RND_LAST);
  assign accept_s  = (state_r == ST_IDLE) && start_valid && !abort;

  // Next-state selection; abort overrides every other transition
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_valid) state_nxt_s = ST_RUN;
          else             state_nxt_s = ST_IDLE;
        end
        ST_RUN: begin
          if (finish_s) state_nxt_s = ST_DONE;
          else          state_nxt_s = ST_RUN;
        end
        ST_DONE: begin
          if (done_ready) state_nxt_s = ST_IDLE;
          else            state_nxt_s = ST_DONE;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Phase and round counters; the final round index is held into DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_r <= '0;
      round_r <= '0;
    end else if (abort || accept_s) begin
      phase_r <= '0;
      round_r <= '0;
    end else if (move_s) begin
      if (phase_r == PH_LAST) begin
        phase_r <= '0;
        if (round_r != RND_LAST) round_r <= round_r + RCW'(1);
        else                     round_r <= round_r;
      end else begin
        phase_r <= phase_r + PHW'(1);
        round_r <= round_r;
      end
    end else begin
      phase_r <= phase_r;
      round_r <= round_r;
    end
  end

  romulus_rc_lfsr u_rc_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (accept_s),
    .step (wrap_s && !finish_s),
    .rc   (rc_s)
  );

  // One-hot phase decode, blanked when idle or stalled
  always_comb begin
    enrnd_s = '0;
    for (int i = 0; i < CLKS_PER_RND; i++) begin
      enrnd_s[i] = step_s && (phase_r == PHW'(i));
    end
  end

  assign start_ready = (state_r == ST_IDLE);
  assign rdi_ready   = (MASKED != 0) && run_s;
  assign constant    = (run_s || done_st_s) ? CONSTW'(rc_s) : '0;
  assign round       = (run_s || done_st_s) ? round_r : '0;
  assign last_round  = run_s && (round_r == RND_LAST);
  assign done_valid  = done_st_s;
  assign enrnd       = enrnd_s;
  assign sen         = |enrnd_s;

endmodule

// File: tb/tb_romulus_round_sched.sv
// Directed self-checking bench: unmasked defaults, masked stalls, completion
// hold, abort, asynchronous reset and single-phase rounds.
module tb_romulus_round_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, abort, rdi_valid, done_ready;
  logic sv_a, sv_m, sv_c;

  logic       a_start_ready, a_rdi_ready, a_sen, a_last_round, a_done_valid;
  logic [5:0] a_constant, a_round;
  logic [3:0] a_enrnd;
  logic       m_start_ready, m_rdi_ready, m_sen, m_last_round, m_done_valid;
  logic [5:0] m_constant, m_round;
  logic [3:0] m_enrnd;
  logic       c_start_ready, c_rdi_ready, c_sen, c_last_round, c_done_valid;
  logic [5:0] c_constant, c_round;
  logic [0:0] c_enrnd;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Hand-derived SKINNY round constants for rounds 0..39
  logic [5:0] rc_tab [40] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
    6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
    6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
    6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A};

  romulus_round_sched u_dut (
    .clk(clk), .rst(rst), .start_valid(sv_a), .start_ready(a_start_ready),
    .abort(abort), .rdi_valid(rdi_valid), .rdi_ready(a_rdi_ready),
    .constant(a_constant), .enrnd(a_enrnd), .sen(a_sen), .round(a_round),
    .last_round(a_last_round), .done_valid(a_done_valid), .done_ready(done_ready));

  romulus_round_sched #(.MASKED(1)) u_msk (
    .clk(clk), .rst(rst), .start_valid(sv_m), .start_ready(m_start_ready),
    .abort(abort), .rdi_valid(rdi_valid), .rdi_ready(m_rdi_ready),
    .constant(m_constant), .enrnd(m_enrnd), .sen(m_sen), .round(m_round),
    .last_round(m_last_round), .done_valid(m_done_valid), .done_ready(done_ready));

  romulus_round_sched #(.CLKS_PER_RND(1)) u_c1 (
    .clk(clk), .rst(rst), .start_valid(sv_c), .start_ready(c_start_ready),
    .abort(abort), .rdi_valid(rdi_valid), .rdi_ready(c_rdi_ready),
    .constant(c_constant), .enrnd(c_enrnd), .sen(c_sen), .round(c_round),
    .last_round(c_last_round), .done_valid(c_done_valid), .done_ready(done_ready));

  task cyc;
    @(posedge clk);
    #2;
  endtask

  task test_reset;
    rst = 1'b0; abort = 1'b0; rdi_valid = 1'b1; done_ready = 1'b0;
    sv_a = 1'b0; sv_m = 1'b0; sv_c = 1'b0;
    repeat (2) cyc;
    #1;
    cmp_cnt++; if ({a_start_ready, m_start_ready, c_start_ready} !== 3'b111) begin err_cnt++; $display("FAIL reset_start_ready got %b exp 111", {a_start_ready, m_start_ready, c_start_ready}); end
    cmp_cnt++; if ({a_constant, a_enrnd, a_sen, a_round, a_last_round, a_done_valid, a_rdi_ready} !== 20'h0) begin err_cnt++; $display("FAIL reset_outs_a got nonzero const=%h en=%b", a_constant, a_enrnd); end
    cmp_cnt++; if ({m_constant, m_enrnd, m_sen, m_round, m_last_round, m_done_valid, m_rdi_ready} !== 20'h0) begin err_cnt++; $display("FAIL reset_outs_m got nonzero rdi_ready=%b en=%b", m_rdi_ready, m_enrnd); end
    cmp_cnt++; if ({c_constant, c_enrnd, c_sen, c_round, c_last_round, c_done_valid, c_rdi_ready} !== 17'h0) begin err_cnt++; $display("FAIL reset_outs_c got nonzero en=%b", c_enrnd); end
    rst = 1'b1;
    repeat (7) cyc;
    #1;
    cmp_cnt++; if (a_start_ready !== 1'b1 || a_enrnd !== 4'b0000) begin err_cnt++; $display("FAIL idle_after_reset got rdy=%b en=%b exp 1/0000", a_start_ready, a_enrnd); end
  endtask

  task automatic test_unmasked;
    logic [3:0] exp_en;
    int r, p;
    sv_a = 1'b1;
    cmp_cnt++; if (a_start_ready !== 1'b1) begin err_cnt++; $display("FAIL unm_start_ready got %b exp 1", a_start_ready); end
    cyc; sv_a = 1'b0; #1;
    for (int k = 1; k <= 160; k++) begin
      r = (k - 1) / 4; p = (k - 1) % 4; exp_en = 4'b0001 << p;
      cmp_cnt++; if (a_constant !== rc_tab[r]) begin err_cnt++; $display("FAIL unm_const k=%0d got %h exp %h", k, a_constant, rc_tab[r]); end
      cmp_cnt++; if (a_enrnd !== exp_en || a_sen !== 1'b1) begin err_cnt++; $display("FAIL unm_enrnd k=%0d got %b/%b exp %b/1", k, a_enrnd, a_sen, exp_en); end
      cmp_cnt++; if (a_round !== 6'(r) || a_last_round !== (r == 39)) begin err_cnt++; $display("FAIL unm_round k=%0d got %0d/%b exp %0d", k, a_round, a_last_round, r); end
      cmp_cnt++; if (a_done_valid !== 1'b0 || a_start_ready !== 1'b0) begin err_cnt++; $display("FAIL unm_busy k=%0d got dv=%b rdy=%b exp 0/0", k, a_done_valid, a_start_ready); end
      cyc; #1;
    end
    cmp_cnt++; if (a_done_valid !== 1'b1) begin err_cnt++; $display("FAIL unm_done_at_161 got %b exp 1", a_done_valid); end
    cmp_cnt++; if (a_constant !== 6'h1A || a_round !== 6'd39) begin err_cnt++; $display("FAIL unm_final got %h/%0d exp 1a/39", a_constant, a_round); end
    cmp_cnt++; if (a_enrnd !== 4'b0000 || a_sen !== 1'b0 || a_last_round !== 1'b0) begin err_cnt++; $display("FAIL unm_done_quiet got %b/%b/%b exp 0", a_enrnd, a_sen, a_last_round); end
  endtask

  task test_done_hold;
    done_ready = 1'b0; sv_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmp_cnt++; if (a_done_valid !== 1'b1 || a_start_ready !== 1'b0) begin err_cnt++; $display("FAIL hold_done i=%0d got dv=%b rdy=%b exp 1/0", i, a_done_valid, a_start_ready); end
      cyc; #1;
    end
    done_ready = 1'b1; sv_a = 1'b0;
    cmp_cnt++; if (a_done_valid !== 1'b1 || a_constant !== 6'h1A) begin err_cnt++; $display("FAIL hold_final got %b/%h exp 1/1a", a_done_valid, a_constant); end
    cyc; #1;
    cmp_cnt++; if (a_start_ready !== 1'b1 || a_done_valid !== 1'b0 || a_constant !== 6'h00) begin err_cnt++; $display("FAIL b2b_idle got rdy=%b dv=%b c=%h exp 1/0/00", a_start_ready, a_done_valid, a_constant); end
    sv_a = 1'b1; done_ready = 1'b0;
    cyc; sv_a = 1'b0; #1;
    cmp_cnt++; if (a_constant !== 6'h01 || a_enrnd !== 4'b0001 || a_round !== 6'd0) begin err_cnt++; $display("FAIL b2b_restart got %h/%b/%0d exp 01/0001/0", a_constant, a_enrnd, a_round); end
  endtask

  task automatic test_abort;
    logic seen_done;
    repeat (48) cyc;
    #1;
    cmp_cnt++; if (a_round !== 6'd12 || a_constant !== 6'h39) begin err_cnt++; $display("FAIL abort_pre got %0d/%h exp 12/39", a_round, a_constant); end
    abort = 1'b1;
    cyc; abort = 1'b0; #1;
    cmp_cnt++; if (a_start_ready !== 1'b1) begin err_cnt++; $display("FAIL abort_idle got rdy=%b exp 1", a_start_ready); end
    cmp_cnt++; if ({a_constant, a_enrnd, a_sen, a_round, a_last_round, a_done_valid} !== 19'h0) begin err_cnt++; $display("FAIL abort_outs got c=%h en=%b r=%0d", a_constant, a_enrnd, a_round); end
    seen_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (a_done_valid === 1'b1) seen_done = 1'b1;
      cyc; #1;
    end
    cmp_cnt++; if (seen_done !== 1'b0) begin err_cnt++; $display("FAIL abort_no_done got %b exp 0", seen_done); end
    sv_a = 1'b1;
    cyc; sv_a = 1'b0; #1;
    cmp_cnt++; if (a_constant !== 6'h01 || a_enrnd !== 4'b0001) begin err_cnt++; $display("FAIL abort_restart got %h/%b exp 01/0001", a_constant, a_enrnd); end
  endtask

  task test_async_reset;
    repeat (80) cyc;
    #1;
    cmp_cnt++; if (a_round !== 6'd20 || a_constant !== 6'h16) begin err_cnt++; $display("FAIL arst_pre got %0d/%h exp 20/16", a_round, a_constant); end
    #1 rst = 1'b0;
    #1;
    cmp_cnt++; if (a_start_ready !== 1'b1 || {a_constant, a_enrnd, a_sen, a_round, a_last_round, a_done_valid} !== 19'h0) begin err_cnt++; $display("FAIL arst_immediate got rdy=%b c=%h en=%b", a_start_ready, a_constant, a_enrnd); end
    #2 rst = 1'b1;
    cyc; #1;
    cmp_cnt++; if (a_start_ready !== 1'b1 || a_constant !== 6'h00 || a_enrnd !== 4'b0000) begin err_cnt++; $display("FAIL arst_idle got rdy=%b c=%h en=%b", a_start_ready, a_constant, a_enrnd); end
  endtask

  task automatic test_masked;
    logic [3:0] exp_en;
    logic stall;
    int eff;
    rdi_valid = 1'b1;
    cmp_cnt++; if (m_rdi_ready !== 1'b0) begin err_cnt++; $display("FAIL msk_idle_rdi got %b exp 0", m_rdi_ready); end
    sv_m = 1'b1;
    cyc; sv_m = 1'b0;
    for (int k = 1; k <= 163; k++) begin
      stall = (k >= 23 && k <= 25);
      rdi_valid = !stall;
      #1;
      eff = (k < 23) ? k - 1 : (stall ? 22 : k - 4);
      exp_en = stall ? 4'b0000 : (4'b0001 << (eff % 4));
      cmp_cnt++; if (m_enrnd !== exp_en || m_sen !== !stall) begin err_cnt++; $display("FAIL msk_enrnd k=%0d got %b/%b exp %b", k, m_enrnd, m_sen, exp_en); end
      cmp_cnt++; if (m_constant !== rc_tab[eff / 4] || m_round !== 6'(eff / 4)) begin err_cnt++; $display("FAIL msk_round k=%0d got %h/%0d exp %h/%0d", k, m_constant, m_round, rc_tab[eff / 4], eff / 4); end
      cmp_cnt++; if (m_rdi_ready !== 1'b1 || m_done_valid !== 1'b0) begin err_cnt++; $display("FAIL msk_hs k=%0d got rr=%b dv=%b exp 1/0", k, m_rdi_ready, m_done_valid); end
      cyc;
    end
    rdi_valid = 1'b1;
    #1;
    cmp_cnt++; if (m_done_valid !== 1'b1 || m_constant !== 6'h1A || m_enrnd !== 4'b0000) begin err_cnt++; $display("FAIL msk_done_164 got dv=%b c=%h en=%b exp 1/1a/0", m_done_valid, m_constant, m_enrnd); end
    cmp_cnt++; if (m_rdi_ready !== 1'b0) begin err_cnt++; $display("FAIL msk_done_rdi got %b exp 0", m_rdi_ready); end
    done_ready = 1'b1;
    cyc; done_ready = 1'b0; #1;
    cmp_cnt++; if (m_start_ready !== 1'b1) begin err_cnt++; $display("FAIL msk_back_idle got %b exp 1", m_start_ready); end
  endtask

  task test_clk1;
    sv_c = 1'b1;
    cyc; sv_c = 1'b0; #1;
    for (int k = 1; k <= 40; k++) begin
      cmp_cnt++; if (c_enrnd !== 1'b1 || c_sen !== 1'b1) begin err_cnt++; $display("FAIL c1_enrnd k=%0d got %b/%b exp 1/1", k, c_enrnd, c_sen); end
      cmp_cnt++; if (c_constant !== rc_tab[k - 1] || c_round !== 6'(k - 1)) begin err_cnt++; $display("FAIL c1_const k=%0d got %h/%0d exp %h/%0d", k, c_constant, c_round, rc_tab[k - 1], k - 1); end
      cyc; #1;
    end
    cmp_cnt++; if (c_done_valid !== 1'b1 || c_enrnd !== 1'b0 || c_constant !== 6'h1A) begin err_cnt++; $display("FAIL c1_done got dv=%b en=%b c=%h exp 1/0/1a", c_done_valid, c_enrnd, c_constant); end
    done_ready = 1'b1;
    cyc; done_ready = 1'b0; #1;
    cmp_cnt++; if (c_start_ready !== 1'b1) begin err_cnt++; $display("FAIL c1_back_idle got %b exp 1", c_start_ready); end
  endtask

  initial begin
    test_reset;
    test_unmasked;
    test_done_hold;
    test_abort;
    test_async_reset;
    test_masked;
    test_clk1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
